wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, the address width.
REQ-002 SHALL have parameter DW, default 32, the data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the number of ack-less cycles before the bus is aborted (legal range 2..255).
REQ-004 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have, for each of the two masters n = 0 (instruction fetch) and n = 1 (load/store), these ports:
- i_mn_cyc / i_mn_stb / i_mn_we: input, 1 each.
- i_mn_addr: input, AW.
- i_mn_data: input, DW.
- o_mn_data: output, DW, the read data.
- o_mn_ack / o_mn_stall / o_mn_err: output, 1 each.
REQ-007 SHALL have the shared slave port:
- o_wb_cyc / o_wb_stb / o_wb_we: output, 1 each.
- o_wb_addr: output, AW.
- o_wb_data: output, DW.
- i_wb_data: input, DW.
- i_wb_ack / i_wb_stall: input, 1 each.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, OWN0, OWN1.
REQ-009 SHALL, in IDLE, drive o_wb_cyc = o_wb_stb = 0, and drive stall = 1, ack = 0 and err = 0 to both masters.
REQ-010 SHALL, in IDLE, arbitrate on i_mn_cyc:
- Only one master requesting: go to OWNn on the next edge.
- Both requesting: go to OWNn for the master not granted last.
- The last-granted flag resets to 1, so master 0 wins the first tie.
REQ-011 SHALL, in OWNn, route master n's cyc, stb, we, addr and data combinationally to the slave port.
REQ-012 SHALL, in OWNn, route i_wb_ack and i_wb_stall to master n, and drive i_wb_data onto o_mn_data.
REQ-013 SHALL, in OWNn, drive stall = 1 and ack = 0 to the other master.
REQ-014 SHALL hold the grant while i_mn_cyc = 1; a request from the other master never preempts.
REQ-015 SHALL return OWNn to IDLE on the edge where i_mn_cyc = 0, so there is at least one IDLE cycle between owners.
REQ-016 SHALL give a grant latency of exactly 1 cycle from cyc rising in IDLE to the slave seeing cyc.
REQ-017 SHALL keep an 8-bit watchdog counter with these rules:
- Cleared in IDLE, and on any cycle with i_wb_ack = 1.
- Otherwise incremented each OWNn cycle.
- Saturates at TIMEOUT.
REQ-018 SHALL, when the counter equals TIMEOUT in OWNn:
- Pulse o_mn_err for 1 cycle, with ack = 0.
- Force o_wb_cyc = o_wb_stb = 0 in that same cycle.
- Go to IDLE on the next edge.
REQ-019 SHALL, after an error, grant to the other master if it is requesting, because the last-granted flag = n.
REQ-020 SHALL, if i_wb_ack and the timeout condition coincide, treat it as an ack: no err, counter cleared.
REQ-021 SHALL ignore i_wb_ack and i_wb_data in IDLE; they are not forwarded to either master.
REQ-022 SHALL mux o_mn_data combinationally from i_wb_data without registering it; data is valid only while o_mn_ack = 1.

Reset
REQ-023 SHALL, on reset = 0 at a rising edge, set: state IDLE, counter 0, last-granted 1, all outputs inactive (cyc, stb, we, ack, err = 0; stall = 1; addr and data = 0).
REQ-024 SHALL abandon an in-flight transfer when reset is asserted mid-operation, with no err pulse.

Structure
REQ-025 SHALL take the state encoding (IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10) and the bus width defaults from the shared SoC package.
REQ-026 SHALL place the watchdog in sub-module wb_watchdog (inputs clear and enable; output expired); the FSM and muxes stay in wb_master_arbiter.

Verification
REQ-027 Master 0 alone: single read at 0xb0000000, slave acks 2 cycles after stb with 0x12345678 -> o_m0_ack = 1, o_m0_data = 0x12345678, o_m1_stall = 1 throughout, bus in IDLE 1 cycle after m0 drops cyc.
REQ-028 Both masters raise cyc in the same cycle after reset -> OWN0 first; when m0 drops cyc, 1 IDLE cycle, then OWN1; the next tie goes to m0.
REQ-029 Master 1 write 0xdeadbeef to 0xb000fffc with i_wb_stall = 1 for 3 cycles -> o_m1_stall follows i_wb_stall; slave sees we = 1, addr and data stable until stall falls.
REQ-030 TIMEOUT = 4, slave never acks m1 -> o_m1_err pulses exactly 1 cycle, 4 cycles after grant; o_wb_cyc = 0 that cycle; pending m0 granted 2 cycles later.
REQ-031 reset = 0 asserted while in OWN1 with a transfer outstanding -> next cycle state IDLE, all outputs at reset values, o_m1_err = 0; a late i_wb_ack is not forwarded.
REQ-032 Ack and timeout coincide (TIMEOUT = 4, ack on the 4th cycle) -> o_m0_ack = 1, o_m0_err = 0, grant retained.

Source files
------------

// File: rtl/wb_master_arbiter_pkg.sv
// Shared SoC bus definitions: arbiter state encoding, default bus widths and
// the two-master grant selection rule.
package wb_master_arbiter_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    // Ties go to the master that was not granted last.
    function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1, input logic last);
        arb_state_e pick;
        case ({cyc0, cyc1})
            2'b11:   pick = last ? ST_OWN0 : ST_OWN1;
            2'b10:   pick = ST_OWN0;
            2'b01:   pick = ST_OWN1;
            default: pick = ST_IDLE;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// Saturating ack-less cycle counter; o_expired is high while the count sits
// at TIMEOUT.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] r_count;

    // Count ack-less owned cycles, saturating at LIMIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && (r_count < LIMIT)) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for the whole cycle,
// combinational bus routing, watchdog abort with a one-cycle err pulse.
module wb_master_arbiter #(
    parameter int AW      = wb_master_arbiter_pkg::WB_AW,
    parameter int DW      = wb_master_arbiter_pkg::WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    output logic [DW-1:0] o_m0_data,
    output logic          o_m0_ack,
    output logic          o_m0_stall,
    output logic          o_m0_err,
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    output logic [DW-1:0] o_m1_data,
    output logic          o_m1_ack,
    output logic          o_m1_stall,
    output logic          o_m1_err,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic [DW-1:0] i_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall
);

    import wb_master_arbiter_pkg::*;

    arb_state_e r_state;
    arb_state_e w_next_state;
    logic       r_last;
    logic       w_next_last;
    logic       w_expired;
    logic       w_owned;
    logic       w_timeout;

    assign w_owned   = (r_state != ST_IDLE);
    // An ack arriving in the expiry cycle wins over the abort.
    assign w_timeout = w_owned & w_expired & ~i_wb_ack;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (~w_owned | i_wb_ack),
        .i_enable  (w_owned),
        .o_expired (w_expired)
    );

    // State and last-granted registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
        end
    end

    // Next-state: arbitrate in IDLE, release on cyc drop or abort.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        case (r_state)
            ST_IDLE: begin
                w_next_state = arb_pick(i_m0_cyc, i_m1_cyc, r_last);
                if (w_next_state == ST_OWN0) begin
                    w_next_last = 1'b0;
                end else if (w_next_state == ST_OWN1) begin
                    w_next_last = 1'b1;
                end else begin
                    w_next_last = r_last;
                end
            end
            ST_OWN0: begin
                if (!i_m0_cyc || w_timeout) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!i_m1_cyc || w_timeout) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OWN1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_last  = 1'b1;
            end
        endcase
    end

    // Bus routing: owner drives the slave, slave responses go to the owner only.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_m0_data  = '0;
        o_m0_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m0_err   = 1'b0;
        o_m1_data  = '0;
        o_m1_ack   = 1'b0;
        o_m1_stall = 1'b1;
        o_m1_err   = 1'b0;
        case (r_state)
            ST_OWN0: begin
                o_wb_cyc   = i_m0_cyc & ~w_timeout;
                o_wb_stb   = i_m0_stb & ~w_timeout;
                o_wb_we    = i_m0_we;
                o_wb_addr  = i_m0_addr;
                o_wb_data  = i_m0_data;
                o_m0_data  = i_wb_data;
                o_m0_ack   = i_wb_ack;
                o_m0_stall = i_wb_stall;
                o_m0_err   = w_timeout;
            end
            ST_OWN1: begin
                o_wb_cyc   = i_m1_cyc & ~w_timeout;
                o_wb_stb   = i_m1_stb & ~w_timeout;
                o_wb_we    = i_m1_we;
                o_wb_addr  = i_m1_addr;
                o_wb_data  = i_m1_data;
                o_m1_data  = i_wb_data;
                o_m1_ack   = i_wb_ack;
                o_m1_stall = i_wb_stall;
                o_m1_err   = w_timeout;
            end
            default: begin
                o_wb_cyc   = 1'b0;
                o_m0_stall = 1'b1;
                o_m1_stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter (TIMEOUT = 4): directed table, hand sequences
// for the bus scenarios, and random traffic against a cycle-level owner model.
module tb_wb_master_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata, wb_addr, wb_wdata, wb_rdata;
    logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_stall;

    always #5 clk = ~clk;

    wb_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
        .i_m0_addr(m0_addr), .i_m0_data(m0_wdata), .o_m0_data(m0_rdata),
        .o_m0_ack(m0_ack), .o_m0_stall(m0_stall), .o_m0_err(m0_err),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
        .i_m1_addr(m1_addr), .i_m1_data(m1_wdata), .o_m1_data(m1_rdata),
        .o_m1_ack(m1_ack), .o_m1_stall(m1_stall), .o_m1_err(m1_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .i_wb_data(wb_rdata),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (-1 none), who was granted last,
    // and how many ack-less cycles the owner has accumulated.
    int md_owner = -1;
    int md_last  = 1;
    int md_cnt   = 0;

    typedef struct packed {
        logic       rst;
        logic       c0;
        logic       c1;
        logic       ack;
        logic [6:0] exp;   // {wb_cyc, ack0, ack1, err0, err1, stall0, stall1}
    } vec_t;

    vec_t tbl [25];

    function automatic logic [136:0] model_out();
        logic        cyc, stb, we, tmo;
        logic [31:0] a, d;
        logic [34:0] r0, r1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; a = 32'h0; d = 32'h0;
        r0 = {32'h0, 1'b0, 1'b1, 1'b0};
        r1 = {32'h0, 1'b0, 1'b1, 1'b0};
        tmo = (md_owner >= 0) && (md_cnt == TO) && !wb_ack;
        if (md_owner == 0) begin
            cyc = m0_cyc & ~tmo; stb = m0_stb & ~tmo; we = m0_we;
            a = m0_addr; d = m0_wdata;
            r0 = {wb_rdata, wb_ack, wb_stall, tmo};
        end else if (md_owner == 1) begin
            cyc = m1_cyc & ~tmo; stb = m1_stb & ~tmo; we = m1_we;
            a = m1_addr; d = m1_wdata;
            r1 = {wb_rdata, wb_ack, wb_stall, tmo};
        end
        return {cyc, stb, we, a, d, r0, r1};
    endfunction

    task automatic model_update();
        logic tmo;
        logic own_cyc;
        tmo = (md_owner >= 0) && (md_cnt == TO) && !wb_ack;
        own_cyc = (md_owner == 0) ? m0_cyc : m1_cyc;
        if (!rst_n) begin
            md_owner = -1; md_last = 1; md_cnt = 0;
        end else if (md_owner < 0) begin
            md_cnt = 0;
            if (m0_cyc && m1_cyc) begin
                md_owner = 1 - md_last; md_last = md_owner;
            end else if (m0_cyc) begin
                md_owner = 0; md_last = 0;
            end else if (m1_cyc) begin
                md_owner = 1; md_last = 1;
            end
        end else begin
            if (wb_ack) md_cnt = 0;
            else if (md_cnt < TO) md_cnt = md_cnt + 1;
            if (!own_cyc || tmo) md_owner = -1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Let combinational outputs settle, then compare everything with the model.
    task automatic settle(input string tag);
        logic [136:0] act, exp;
        #1;
        act = {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata,
               m0_rdata, m0_ack, m0_stall, m0_err,
               m1_rdata, m1_ack, m1_stall, m1_err};
        exp = model_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_%s actual %h required %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        wb_ack = 1'b0; wb_stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        m0_addr = 32'h1000_0000; m0_wdata = 32'h0000_0011;
        m1_addr = 32'h2000_0000; m1_wdata = 32'h0000_0022;
        wb_rdata = 32'h0a0a_0a0a;

        // rst c0 c1 ack | cyc a0 a1 e0 e1 s0 s1
        tbl[0]  = 11'b1110_0000011;  // tie in IDLE after reset
        tbl[1]  = 11'b1111_1100001;  // m0 won, acked
        tbl[2]  = 11'b1010_0000001;  // m0 drops cyc
        tbl[3]  = 11'b1010_0000011;  // one IDLE cycle
        tbl[4]  = 11'b1010_1000010;  // m1 owns, count 0
        tbl[5]  = 11'b1110_1000010;  // m0 pending, no preempt
        tbl[6]  = 11'b1110_1000010;
        tbl[7]  = 11'b1110_1000010;
        tbl[8]  = 11'b1110_0000110;  // count 4: err to m1, bus cyc forced low
        tbl[9]  = 11'b1110_0000011;  // IDLE, tie goes to m0
        tbl[10] = 11'b1110_1000001;
        tbl[11] = 11'b1110_1000001;
        tbl[12] = 11'b1110_1000001;
        tbl[13] = 11'b1110_1000001;
        tbl[14] = 11'b1111_1100001;  // ack coincides with expiry
        tbl[15] = 11'b1110_1000001;  // grant retained, no err
        tbl[16] = 11'b1010_0000001;
        tbl[17] = 11'b1010_0000011;
        tbl[18] = 11'b1010_1000010;  // m1 owns
        tbl[19] = 11'b0010_1000010;  // reset mid-transfer
        tbl[20] = 11'b1001_0000011;  // late ack not forwarded
        tbl[21] = 11'b1110_0000011;  // tie after reset
        tbl[22] = 11'b1110_1000001;  // m0 wins again
        tbl[23] = 11'b1000_0000001;
        tbl[24] = 11'b1000_0000011;

        tick();
        tick();

        for (int i = 0; i < 25; i++) begin
            rst_n  = tbl[i].rst;
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0; m0_we = 1'b0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1; m1_we = 1'b1;
            wb_ack = tbl[i].ack; wb_stall = 1'b0;
            settle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d", i),
                {57'd0, wb_cyc, m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall},
                {57'd0, tbl[i].exp});
            tick();
        end

        // Master 0 single read, slave acks two cycles after stb.
        idle_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'hb000_0000;
        wb_rdata = 32'hdead_0000;
        settle("rd_req");
        chk("rd_idle_cyc", {63'd0, wb_cyc}, 64'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            settle("rd_wait");
            chk("rd_bus_addr", {31'd0, wb_cyc, wb_addr}, {31'd1, 32'hb000_0000});
            chk("rd_m1_stall", {63'd0, m1_stall}, 64'd1);
            tick();
        end
        wb_ack = 1'b1; wb_rdata = 32'h1234_5678;
        settle("rd_ack");
        chk("rd_ack_data", {31'd0, m0_ack, m0_rdata}, {31'd1, 32'h1234_5678});
        chk("rd_m1_stall", {63'd0, m1_stall}, 64'd1);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; wb_ack = 1'b0;
        settle("rd_drop");
        tick();
        settle("rd_idle");
        chk("rd_idle_after", {62'd0, wb_cyc, m1_stall}, 64'd1);
        tick();

        // Master 1 write held off by three stall cycles.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
        m1_addr = 32'hb000_fffc; m1_wdata = 32'hdead_beef; wb_stall = 1'b1;
        settle("wr_req");
        tick();
        for (int k = 0; k < 3; k++) begin
            settle("wr_stall");
            chk("wr_stall_fwd", {63'd0, m1_stall}, 64'd1);
            chk("wr_bus", {wb_we, wb_addr[30:0], wb_wdata}, {1'b1, 31'h3000_fffc, 32'hdead_beef});
            tick();
        end
        wb_stall = 1'b0; wb_ack = 1'b1;
        settle("wr_ack");
        chk("wr_stall_low", {62'd0, m1_stall, m1_ack}, 64'd1);
        tick();
        idle_inputs();
        settle("wr_end");
        tick();

        // Random traffic, occasional reset, sparse acks so aborts happen.
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            m0_cyc   = ($urandom_range(0, 3) != 0);
            m1_cyc   = ($urandom_range(0, 3) != 0);
            m0_stb   = $urandom_range(0, 1);
            m1_stb   = $urandom_range(0, 1);
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m0_addr  = $urandom; m0_wdata = $urandom;
            m1_addr  = $urandom; m1_wdata = $urandom;
            wb_rdata = $urandom;
            wb_ack   = ($urandom_range(0, 4) == 0);
            wb_stall = $urandom_range(0, 1);
            settle("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
